// File: rtl/controlador_elevador.sv
// Four-floor elevator controller: registers floor calls, sequences the door
// (open/close/reopen) and moves the cabin one floor per TEMPO_ANDAR cycles.
module controlador_elevador #(
  parameter int TEMPO_ANDAR = 8,
  parameter int TEMPO_PORTA = 10
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic [3:0] botao,
  input  logic       port_a,
  input  logic       port_f,
  output logic       control_port,
  output logic [1:0] andar,
  output logic       sobe,
  output logic       desce,
  output logic [3:0] pendentes,
  output logic [2:0] estado
);

  localparam logic [2:0] ABERTA   = 3'd0;
  localparam logic [2:0] FECHANDO = 3'd1;
  localparam logic [2:0] MOVENDO  = 3'd2;
  localparam logic [2:0] ABRINDO  = 3'd3;

  localparam int WP = $clog2(TEMPO_PORTA + 1);
  localparam int WA = $clog2(TEMPO_ANDAR + 1);
  localparam logic [WP-1:0] PORTA_MAX = WP'(TEMPO_PORTA - 1);
  localparam logic [WA-1:0] ANDAR_MAX = WA'(TEMPO_ANDAR - 1);

  logic          dir;
  logic [WP-1:0] cnt_porta;
  logic [WA-1:0] cnt_andar;
  logic [3:0]    aqui;
  logic [3:0]    acima;
  logic [3:0]    abaixo;
  logic [3:0]    pend_set;
  logic [1:0]    prox_andar;
  logic          vai_subir;
  logic          vai_descer;

  always_comb begin
    aqui     = 4'b0001 << andar;
    pend_set = pendentes | botao;
    acima    = '0;
    abaixo   = '0;
    case (andar)
      2'd0: begin acima = 4'b1110; abaixo = 4'b0000; end
      2'd1: begin acima = 4'b1100; abaixo = 4'b0001; end
      2'd2: begin acima = 4'b1000; abaixo = 4'b0011; end
      default: begin acima = 4'b0000; abaixo = 4'b0111; end
    endcase
    acima  = acima & pendentes;
    abaixo = abaixo & pendentes;
    // Keep the current direction while it still has work; otherwise reverse.
    vai_subir  = (|acima) && (dir || !(|abaixo));
    vai_descer = (|abaixo) && (!dir || !(|acima));
    prox_andar = dir ? andar + 2'd1 : andar - 2'd1;
  end

  assign control_port = (estado == FECHANDO) || (estado == MOVENDO);
  assign sobe         = (estado == MOVENDO) && dir;
  assign desce        = (estado == MOVENDO) && !dir;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      estado    <= ABERTA;
      andar     <= '0;
      pendentes <= '0;
      dir       <= 1'b1;
      cnt_porta <= '0;
      cnt_andar <= '0;
    end else begin
      pendentes <= pend_set;
      case (estado)
        ABERTA: begin
          pendentes <= pend_set & ~aqui;
          if (botao[andar])
            cnt_porta <= '0;
          else if (port_a && cnt_porta != PORTA_MAX)
            cnt_porta <= cnt_porta + 1'b1;
          if (cnt_porta == PORTA_MAX && |(pendentes & ~aqui))
            estado <= FECHANDO;
        end
        FECHANDO: begin
          if (botao[andar] || pendentes[andar]) begin
            estado <= ABRINDO;
          end else if (port_f) begin
            cnt_andar <= '0;
            if (vai_subir || vai_descer) begin
              estado <= MOVENDO;
              dir    <= vai_subir;
            end else begin
              estado <= ABRINDO;
            end
          end
        end
        MOVENDO: begin
          if (cnt_andar == ANDAR_MAX) begin
            cnt_andar <= '0;
            andar     <= prox_andar;
            // Terminal floors force a stop so the floor index never wraps.
            if (pend_set[prox_andar] || (dir && prox_andar == 2'd3) ||
                (!dir && prox_andar == 2'd0))
              estado <= ABRINDO;
          end else begin
            cnt_andar <= cnt_andar + 1'b1;
          end
        end
        ABRINDO: begin
          if (port_a) begin
            estado    <= ABERTA;
            cnt_porta <= '0;
            pendentes <= pend_set & ~aqui;
          end
        end
        default: estado <= ABRINDO;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_elevador.sv
// Bench for controlador_elevador: directed elevator scenarios plus random calls,
// compared every cycle against a floor/queue level model and a door model.
module tb_controlador_elevador;

  localparam int TA = 4;
  localparam int TP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] botao = '0;
  logic       port_a = 1'b1;
  logic       port_f = 1'b0;
  logic       control_port;
  logic [1:0] andar;
  logic       sobe;
  logic       desce;
  logic [3:0] pendentes;
  logic [2:0] estado;

  controlador_elevador #(.TEMPO_ANDAR(TA), .TEMPO_PORTA(TP)) dut (
    .clock_in(clk), .reset(rst), .botao(botao), .port_a(port_a), .port_f(port_f),
    .control_port(control_port), .andar(andar), .sobe(sobe), .desce(desce),
    .pendentes(pendentes), .estado(estado)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model: 0 open, 1 closing, 2 moving, 3 opening
  int       m_st = 0;
  int       m_andar = 0;
  int       m_dwell = 0;
  int       m_trav = 0;
  bit       m_dir = 1'b1;
  bit [3:0] m_pend = '0;

  int door_hi = 0;
  int door_lo = 4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired got timeout required event at %0t", name, $time);
  endtask

  task automatic model_step();
    bit [3:0] nxt;
    bit others, up_req, dn_req;
    int nst;
    if (rst) begin
      m_st = 0; m_andar = 0; m_pend = '0; m_dir = 1'b1; m_dwell = 0; m_trav = 0;
      return;
    end
    nxt = m_pend | botao;
    nst = m_st;
    case (m_st)
      0: begin
        others = 1'b0;
        for (int f = 0; f < 4; f++) if (f != m_andar && m_pend[f]) others = 1'b1;
        if (m_dwell == TP - 1 && others) nst = 1;
        if (botao[m_andar]) m_dwell = 0;
        else if (port_a && m_dwell < TP - 1) m_dwell++;
        nxt[m_andar] = 1'b0;
      end
      1: begin
        if (botao[m_andar] || m_pend[m_andar]) nst = 3;
        else if (port_f) begin
          up_req = 1'b0; dn_req = 1'b0;
          for (int f = 0; f < 4; f++) begin
            if (f > m_andar && m_pend[f]) up_req = 1'b1;
            if (f < m_andar && m_pend[f]) dn_req = 1'b1;
          end
          m_trav = 0;
          nst = 2;
          if (m_dir) begin
            if (up_req) m_dir = 1'b1; else if (dn_req) m_dir = 1'b0; else nst = 3;
          end else begin
            if (dn_req) m_dir = 1'b0; else if (up_req) m_dir = 1'b1; else nst = 3;
          end
        end
      end
      2: begin
        m_trav++;
        if (m_trav == TA) begin
          m_trav = 0;
          m_andar = m_dir ? m_andar + 1 : m_andar - 1;
          if (nxt[m_andar] || (m_dir && m_andar == 3) || (!m_dir && m_andar == 0)) nst = 3;
        end
      end
      default: begin
        if (port_a) begin nst = 0; m_dwell = 0; nxt[m_andar] = 1'b0; end
      end
    endcase
    m_st = nst;
    m_pend = nxt;
  endtask

  task automatic door_update();
    if (control_port) begin
      if (door_hi < 9) door_hi++;
      door_lo = 0;
    end else begin
      if (door_lo < 9) door_lo++;
      door_hi = 0;
    end
    port_f = (door_hi >= 4);
    port_a = (door_lo >= 4);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    door_update();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("estado", estado, m_st);
      chk("andar", andar, m_andar);
      chk("pendentes", pendentes, m_pend);
      chk("control_port", control_port, (m_st == 1 || m_st == 2));
      chk("sobe", sobe, (m_st == 2 && m_dir));
      chk("desce", desce, (m_st == 2 && !m_dir));
    end
  end

  initial begin
    int n, n_open, n_sobe, n_desce, max_andar, r;
    bit saw_abrindo, desce_early;

    // Reset and first trip 0 -> 2
    rst = 1'b1; botao = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_estado", estado, 0);
    chk("rst_andar", andar, 0);
    chk("rst_pendentes", pendentes, 0);
    chk("rst_control", control_port, 0);
    chk("rst_sobe_desce", {sobe, desce}, 0);
    rst = 1'b0; botao = 4'b0100; n_open = 1;
    tick();
    botao = '0;
    n = 0;
    while (estado == 3'd0 && n < 50) begin n_open++; tick(); n++; end
    if (n >= 50) timeout_fail("s1_wait_close");
    chk("s1_open_cycles", n_open, 3);
    chk("s1_fechando", estado, 1);
    n = 0; n_sobe = 0; saw_abrindo = 1'b0;
    while (estado != 3'd0 && n < 100) begin
      tick(); n++;
      if (sobe) n_sobe++;
      if (estado == 3'd3) saw_abrindo = 1'b1;
    end
    if (n >= 100) timeout_fail("s1_wait_open");
    chk("s1_sobe_cycles", n_sobe, 8);
    chk("s1_andar", andar, 2);
    chk("s1_pendentes", pendentes, 0);
    chk("s1_saw_abrindo", saw_abrindo, 1);

    // From 2 going up with calls at 3 and 0: serve 3 first, then reverse
    botao = 4'b1001;
    tick();
    botao = '0;
    n = 0; n_sobe = 0; n_desce = 0; max_andar = 0; desce_early = 1'b0;
    while (!(estado == 3'd0 && andar == 2'd0 && pendentes == 4'd0) && n < 300) begin
      tick(); n++;
      if (sobe) n_sobe++;
      if (desce) n_desce++;
      if (int'(andar) > max_andar) max_andar = andar;
      if (desce && max_andar < 3) desce_early = 1'b1;
    end
    if (n >= 300) timeout_fail("s2_wait_done");
    chk("s2_sobe_cycles", n_sobe, 4);
    chk("s2_desce_cycles", n_desce, 12);
    chk("s2_max_andar", max_andar, 3);
    chk("s2_desce_before_top", desce_early, 0);

    // Call for floor 1 arriving on the very cycle the cabin steps 0 -> 1
    botao = 4'b1000;
    tick();
    botao = '0;
    n = 0;
    while (!sobe && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("s4_wait_move");
    repeat (3) tick();
    chk("s4_pre_step_andar", andar, 0);
    botao = 4'b0010;
    tick();
    botao = '0;
    chk("s4_stop_andar", andar, 1);
    chk("s4_stop_estado", estado, 3);
    chk("s4_pendentes", pendentes, 4'b1010);
    n = 0;
    while (!(estado == 3'd0 && andar == 2'd3 && pendentes == 4'd0) && n < 200) begin tick(); n++; end
    if (n >= 200) timeout_fail("s4_wait_top");

    // Own-floor call while closing reopens without moving
    botao = 4'b0001;
    tick();
    botao = '0;
    n = 0;
    while (estado != 3'd1 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("s3_wait_close");
    botao = 4'b1000;
    tick();
    botao = '0;
    chk("s3_reopen_estado", estado, 3);
    chk("s3_reopen_control", control_port, 0);
    chk("s3_reopen_andar", andar, 3);
    chk("s3_no_move", {sobe, desce}, 0);

    // Reset while travelling down through floor 1
    n = 0;
    while (!(estado == 3'd2 && andar == 2'd1) && n < 200) begin tick(); n++; end
    if (n >= 200) timeout_fail("s5_wait_andar1");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_estado", estado, 0);
    chk("s5_andar", andar, 0);
    chk("s5_sobe", sobe, 0);
    chk("s5_desce", desce, 0);
    chk("s5_control", control_port, 0);
    chk("s5_pendentes", pendentes, 0);

    // Idle with no calls
    repeat (50) begin
      tick();
      chk("s6_idle_control", control_port, 0);
      chk("s6_idle_estado", estado, 0);
    end

    // Random calls with occasional reset, model-checked every cycle
    repeat (3000) begin
      r = $urandom_range(0, 15);
      if (r == 0) botao = 4'($urandom);
      else if (r == 1) botao = 4'(1 << $urandom_range(0, 3));
      else botao = '0;
      rst = ($urandom_range(0, 799) == 0);
      tick();
    end
    rst = 1'b0;
    botao = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
